// File: rtl/mcp_run_controller.sv
// Host-side run controller for the multi-cycle processor: restart-and-run, single-step,
// resume, and halting on host stop, cycle budget or a masked flag condition.
module mcp_run_controller #(
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Step,
    input  logic             Resume,
    input  logic             Stop,
    input  logic [CNT_W-1:0] CycleLimit,
    input  logic [3:0]       FlagMask,
    input  logic [3:0]       FlagMatch,
    input  logic [3:0]       FlagReg,
    output logic             Run,
    output logic             CpuReset,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       HaltCause,
    output logic [CNT_W-1:0] CyclesRun,
    output logic [3:0]       FlagSnap
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET_CPU = 3'd1,
        RUN       = 3'd2,
        STEP      = 3'd3,
        HALTED    = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [RC_W-1:0] rst_cnt;
    logic [CNT_W:0]  count_plus_one;
    logic            limit_hit;
    logic            flag_hit;
    logic            halt_hit;
    logic [1:0]      halt_code;
    logic            run_d;
    logic            cpu_reset_d;
    logic            busy_d;
    logic            done_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Widened by one bit so the budget compare stays correct at a saturated counter
    assign count_plus_one = {1'b0, CyclesRun} + 1'b1;
    assign limit_hit      = (CycleLimit != '0) && (count_plus_one >= {1'b0, CycleLimit});
    assign flag_hit       = (FlagMask != 4'b0000) &&
                            ((FlagReg & FlagMask) == (FlagMatch & FlagMask));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        halt_hit   = 1'b0;
        halt_code  = 2'b00;
        if (Stop) begin
            halt_hit  = 1'b1;
            halt_code = 2'b01;
        end else if (limit_hit) begin
            halt_hit  = 1'b1;
            halt_code = 2'b10;
        end else if (flag_hit) begin
            halt_hit  = 1'b1;
            halt_code = 2'b11;
        end
        case (state)
            IDLE: begin
                if (Start)     state_next = RESET_CPU;
                else if (Step) state_next = STEP;
            end
            RESET_CPU: begin
                if (rst_cnt == RC_LAST) state_next = RUN;
            end
            RUN: begin
                if (Start)         state_next = RESET_CPU;
                else if (halt_hit) state_next = HALTED;
            end
            STEP: begin
                state_next = HALTED;
            end
            HALTED: begin
                if (Start)       state_next = RESET_CPU;
                else if (Step)   state_next = STEP;
                else if (Resume) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they are registered yet aligned with it
    always_comb begin
        run_d       = 1'b0;
        cpu_reset_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_next)
            RESET_CPU: begin
                cpu_reset_d = 1'b1;
                busy_d      = 1'b1;
            end
            RUN, STEP: begin
                run_d  = 1'b1;
                busy_d = 1'b1;
            end
            HALTED:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Run      <= 1'b0;
            CpuReset <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Run      <= run_d;
            CpuReset <= cpu_reset_d;
            Busy     <= busy_d;
            Done     <= done_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rst_cnt   <= '0;
            CyclesRun <= '0;
            HaltCause <= 2'b00;
            FlagSnap  <= 4'b0000;
        end else begin
            rst_cnt <= (state == RESET_CPU) ? rst_cnt + 1'b1 : '0;
            if (state_next == RESET_CPU) begin
                CyclesRun <= '0;
                HaltCause <= 2'b00;
            end else begin
                if (state == RUN || state == STEP) begin
                    CyclesRun <= sat_inc(CyclesRun);
                end
                if (state == RUN && state_next == HALTED) begin
                    HaltCause <= halt_code;
                end else if (state == STEP) begin
                    HaltCause <= 2'b00;
                end
            end
            if (state_next == HALTED && state != HALTED) begin
                FlagSnap <= FlagReg;
            end
        end
    end

endmodule

// File: tb/tb_mcp_run_controller.sv
// Bench for mcp_run_controller: halt reports are predicted into a queue and compared
// when Done rises; a 4-bit-counter instance covers counter saturation.
module tb_mcp_run_controller;

    logic        clk = 1'b0;
    logic        reset, start, step, resume, stop;
    logic [15:0] cycle_limit;
    logic [3:0]  cycle_limit_s;
    logic [3:0]  flag_mask, flag_match, flag_reg;

    logic        run, cpu_reset, busy, done;
    logic [1:0]  halt_cause;
    logic [15:0] cycles_run;
    logic [3:0]  flag_snap;

    logic        run_s, cpu_reset_s, busy_s, done_s;
    logic [1:0]  halt_cause_s;
    logic [3:0]  cycles_run_s;
    logic [3:0]  flag_snap_s;

    typedef struct {
        logic [1:0]  cause;
        logic [15:0] cycles;
        logic [3:0]  snap;
        int          run_len;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   run_len  = 0;
    logic run_prev = 1'b0;
    logic done_prev = 1'b0;
    logic [3:0] step_flags [3] = '{4'b1010, 4'b0011, 4'b1111};

    initial forever #5 clk = ~clk;

    mcp_run_controller dut (
        .Clock(clk), .Reset(reset), .Start(start), .Step(step), .Resume(resume), .Stop(stop),
        .CycleLimit(cycle_limit), .FlagMask(flag_mask), .FlagMatch(flag_match), .FlagReg(flag_reg),
        .Run(run), .CpuReset(cpu_reset), .Busy(busy), .Done(done),
        .HaltCause(halt_cause), .CyclesRun(cycles_run), .FlagSnap(flag_snap)
    );

    mcp_run_controller #(.CNT_W(4), .RST_CYCLES(2)) dut_sat (
        .Clock(clk), .Reset(reset), .Start(start), .Step(step), .Resume(resume), .Stop(stop),
        .CycleLimit(cycle_limit_s), .FlagMask(flag_mask), .FlagMatch(flag_match), .FlagReg(flag_reg),
        .Run(run_s), .CpuReset(cpu_reset_s), .Busy(busy_s), .Done(done_s),
        .HaltCause(halt_cause_s), .CyclesRun(cycles_run_s), .FlagSnap(flag_snap_s)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_halt(input logic [1:0] c, input logic [15:0] n,
                               input logic [3:0] s, input int r);
        exp_t e;
        e.cause = c; e.cycles = n; e.snap = s; e.run_len = r;
        exp_q.push_back(e);
    endtask

    task automatic set_limit(input int n);
        cycle_limit   = 16'(n);
        cycle_limit_s = 4'(n);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            cyc(1);
            n++;
        end
        if (done !== 1'b1) check_val({tag, "_done_timeout"}, done, 1);
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (run !== 1'b1 && n < 50) begin
            cyc(1);
            n++;
        end
        if (run !== 1'b1) check_val({tag, "_run_timeout"}, run, 1);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_run"}, run, 0);
        check_val({tag, "_cpu_reset"}, cpu_reset, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_cause"}, halt_cause, 0);
        check_val({tag, "_cycles"}, cycles_run, 0);
        check_val({tag, "_snap"}, flag_snap, 0);
    endtask

    // Halt monitor: tracks the length of the latest Run streak and scores each halt
    always @(negedge clk) begin
        exp_t e;
        if (run === 1'b1) begin
            if (run_prev !== 1'b1) run_len = 0;
            run_len = run_len + 1;
        end
        if (done === 1'b1 && done_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("sb_unexpected_halt", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_val("sb_cause", halt_cause, e.cause);
                check_val("sb_cycles", cycles_run, e.cycles);
                check_val("sb_snap", flag_snap, e.snap);
                check_val("sb_run_len", run_len, e.run_len);
            end
        end
        run_prev  = run;
        done_prev = done;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; step = 1'b0; resume = 1'b0; stop = 1'b0;
        set_limit(0);
        flag_mask = 4'b0000; flag_match = 4'b0000; flag_reg = 4'b0000;
        cyc(3);
        check_idle("reset");
        reset = 1'b0;
        cyc(2);

        // Resume and Stop do nothing from IDLE
        resume = 1'b1; stop = 1'b1;
        cyc(1);
        resume = 1'b0; stop = 1'b0;
        cyc(1);
        check_val("idle_ignore_run", run, 0);
        check_val("idle_ignore_busy", busy, 0);

        // Cycle budget of 5
        set_limit(5);
        expect_halt(2'b10, 16'd5, 4'b0000, 5);
        pulse_start();
        check_val("budget_cpurst_c1", cpu_reset, 1);
        check_val("budget_run_c1", run, 0);
        check_val("budget_busy_c1", busy, 1);
        cyc(1);
        check_val("budget_cpurst_c2", cpu_reset, 1);
        cyc(1);
        check_val("budget_cpurst_c3", cpu_reset, 0);
        check_val("budget_run_c3", run, 1);
        wait_done("budget");
        check_val("budget_run_after", run, 0);
        check_val("budget_busy_after", busy, 0);

        // Flag halt at run cycle 7
        set_limit(0);
        flag_mask = 4'b0100; flag_match = 4'b0100; flag_reg = 4'b0000;
        expect_halt(2'b11, 16'd7, 4'b0100, 7);
        pulse_start();
        wait_run("flag");
        cyc(6);
        flag_reg = 4'b0100;
        cyc(1);
        check_val("flag_run_low", run, 0);
        check_val("flag_done", done, 1);
        flag_reg = 4'b0000;
        flag_mask = 4'b0000;
        cyc(2);

        // Three single steps from IDLE, then resume halted by Stop
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        for (int i = 0; i < 3; i++) begin
            flag_reg = step_flags[i];
            expect_halt(2'b00, 16'(i + 1), step_flags[i], 1);
            step = 1'b1;
            cyc(1);
            step = 1'b0;
            check_val("step_run", run, 1);
            wait_done("step");
            cyc(3);
        end
        flag_reg = 4'b0110;
        expect_halt(2'b01, 16'd5, 4'b0110, 2);
        resume = 1'b1;
        cyc(1);
        resume = 1'b0;
        check_val("resume_run", run, 1);
        check_val("resume_done_low", done, 0);
        cyc(1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check_val("stop_run_low", run, 0);
        check_val("stop_done", done, 1);
        cyc(2);

        // Start and Step together from HALTED, then Stop coinciding with the budget
        flag_reg = 4'b1001;
        set_limit(4);
        expect_halt(2'b01, 16'd4, 4'b1001, 4);
        start = 1'b1; step = 1'b1;
        cyc(1);
        start = 1'b0; step = 1'b0;
        check_val("simul_cpurst", cpu_reset, 1);
        check_val("simul_cycles_clr", cycles_run, 0);
        check_val("simul_run", run, 0);
        wait_run("simul");
        cyc(3);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        wait_done("simul");
        cyc(2);

        // Resume with the budget already spent runs one cycle
        expect_halt(2'b10, 16'd5, 4'b1001, 1);
        resume = 1'b1;
        cyc(1);
        resume = 1'b0;
        wait_done("past_budget");
        cyc(2);

        // Reset during RUN and during RESET_CPU
        set_limit(0);
        pulse_start();
        wait_run("rst_mid");
        cyc(3);
        reset = 1'b1;
        cyc(1);
        check_idle("rst_in_run");
        reset = 1'b0;
        cyc(1);
        pulse_start();
        reset = 1'b1;
        cyc(1);
        check_idle("rst_in_cpurst");
        reset = 1'b0;
        cyc(1);
        set_limit(3);
        flag_reg = 4'b0010;
        expect_halt(2'b10, 16'd3, 4'b0010, 3);
        pulse_start();
        check_val("restart_cpurst_c1", cpu_reset, 1);
        cyc(1);
        check_val("restart_cpurst_c2", cpu_reset, 1);
        cyc(1);
        check_val("restart_run", run, 1);
        wait_done("restart");
        cyc(2);

        // Counter saturation on the 4-bit instance
        set_limit(0);
        flag_reg = 4'b0000;
        expect_halt(2'b01, 16'd20, 4'b0000, 20);
        pulse_start();
        wait_run("sat");
        cyc(19);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check_val("sat_cycles", cycles_run_s, 4'hF);
        check_val("sat_run_low", run_s, 0);
        check_val("sat_done", done_s, 1);
        check_val("sat_cause", halt_cause_s, 2'b01);

        cyc(3);
        check_val("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mcp_run_controller.md
# mcp_run_controller

Host-side execution controller for the multi-cycle processor: drives the processor's `Run` input and a processor-reset request, and watches the processor's `FlagReg` output. It provides the following services:
- restart-and-run
- single-step
- resume
- halt on host stop, on a cycle budget, or on a masked flag condition

It sits between the board/host control logic and the processor top, with one clock shared by both.

## Interface
Parameters:
- `CNT_W`, 16: width of the cycle budget and the cycle counter.
- `RST_CYCLES`, 2: number of cycles `CpuReset` is held high on Start (≥1).

Ports:
- `Clock`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high block reset.
- `Start`  in  1  pulse: reset the processor, clear the counter, then run.
- `Step`  in  1  pulse: run exactly one processor cycle (from IDLE or HALTED).
- `Resume`  in  1  pulse: continue running from HALTED without a processor reset.
- `Stop`  in  1  level/pulse: halt while running.
- `CycleLimit`  in  CNT_W  cycle budget since Start; 0 = unlimited.
- `FlagMask`  in  4  flag bits to compare; 0 = flag halt disabled.
- `FlagMatch`  in  4  required value of masked flags.
- `FlagReg`  in  4  processor flag register (NZCV).
- `Run`  out  1  to processor `Run`.
- `CpuReset`  out  1  processor reset request, ORed with the system reset at top level.
- `Busy`  out  1  high in RESET_CPU, RUN, STEP.
- `Done`  out  1  high in HALTED.
- `HaltCause`  out  2  00 none/step, 01 Stop, 10 cycle limit, 11 flag match.
- `CyclesRun`  out  CNT_W  cycles with `Run`=1 since last Start.
- `FlagSnap`  out  4  `FlagReg` captured on entry to HALTED.

## Operation
- **Reset.** On `Reset`=1 the block enters IDLE. All outputs are 0: `Run`, `CpuReset`, `Busy`, `Done`, `HaltCause`, `CyclesRun` and `FlagSnap`. Reset mid-run aborts immediately, with no halt reporting.
- **States.** The block has five states: IDLE, RESET_CPU, RUN, STEP and HALTED. All outputs are registered.
- **IDLE.**
  - Start → RESET_CPU.
  - Step → STEP.
  - Resume and Stop are ignored.
- **RESET_CPU.**
  - `CpuReset`=1 for exactly `RST_CYCLES` cycles.
  - `CyclesRun` and `HaltCause` are cleared on entry.
  - The block then goes to RUN.
  - All inputs except `Reset` are ignored in this state.
- **RUN.**
  - `Run`=1.
  - Each cycle `CyclesRun` increments, saturating at all-ones.
  - The halt check is evaluated every RUN cycle, in priority order:
    1. `Stop` → cause 01.
    2. `CycleLimit`≠0 and `CyclesRun`+1 ≥ `CycleLimit` → cause 10.
    3. `FlagMask`≠0 and (`FlagReg` & `FlagMask`) == (`FlagMatch` & `FlagMask`) → cause 11.
  - Any hit → HALTED.
  - Start in RUN → RESET_CPU (restart). Start has priority over the halt check.
- **STEP.**
  - `Run`=1 for one cycle and `CyclesRun` increments.
  - The block then enters HALTED with cause 00.
  - Halt conditions are not evaluated.
- **HALTED.**
  - `Done`=1 and `Run`=0.
  - `FlagSnap` is loaded with `FlagReg` on the entry edge.
  - Exits, in priority order: Start → RESET_CPU; Step → STEP; Resume → RUN.
  - `HaltCause` is held until the next halt or Start.
- **Simultaneous inputs.** Priority is Start > Step > Resume; Stop is only meaningful in RUN.
- **Resume past budget.** Resume with `CyclesRun` already ≥ `CycleLimit` (limit ≠ 0) runs exactly one cycle, then halts with cause 10.

## Timing
- Start sampled at edge k:
  - `CpuReset`=1 in cycles k+1 … k+RST_CYCLES.
  - `Run`=1 from cycle k+RST_CYCLES+1.
- `CycleLimit`=N (N≠0): `Run` is high for exactly N consecutive cycles, then low with `Done`=1 in the following cycle and `CyclesRun`=N.
- Stop or flag match observed in RUN cycle t: `Run` stays high in cycle t and is 0 from t+1. `Done`=1 and `FlagSnap` is valid from t+1.
- Step from IDLE/HALTED at edge k: `Run`=1 only in cycle k+1, then `Done`=1 from k+2.
- Resume at edge k: `Run`=1 from k+1. `Done` drops at k+1.
- `FlagReg` is used combinationally in the same cycle; the processor registers it, so there is no combinational loop.

## Test plan
- **Cycle budget.** Reset, then Start with `CycleLimit`=5 and `FlagMask`=0 → `CpuReset` high 2 cycles, `Run` high exactly 5 cycles, `Done`=1, `HaltCause`=10, `CyclesRun`=5.
- **Flag halt.** Start, `CycleLimit`=0, `FlagMask`=4'b0100, `FlagMatch`=4'b0100; drive `FlagReg`=4'b0100 at run cycle 7 → `Run` low next cycle, `HaltCause`=11, `FlagSnap`=4'b0100, `CyclesRun`=7.
- **Step then resume.** Three Steps from IDLE, spaced apart → three single-cycle `Run` pulses, `CyclesRun`=3, `HaltCause`=00. Then Resume with Stop at run cycle 2 → `HaltCause`=01, `CyclesRun`=5.
- **Simultaneous events.** Start and Step in the same cycle from HALTED → RESET_CPU path taken, `CyclesRun` cleared. Stop and limit hit in the same cycle → `HaltCause`=01.
- **Reset mid-operation.** Reset asserted mid-RUN, and again mid-RESET_CPU → next cycle: all outputs 0, state IDLE; a later Start behaves normally.
- **Saturation.** `CNT_W`=4, `CycleLimit`=0, run 20 cycles, then Stop → `CyclesRun`=15 (saturated), `Run` low after Stop.
